ysyx_23060236_icache_refill: RTL and testbench

- Fetch-side controller between the IFU and the instruction cache array.
- Latches an IFU fetch request and looks it up in the cache array.
- On a miss, issues one AXI4 INCR read burst for the whole 32-byte line and writes each returned beat into the array through its write port. It then re-checks the line and returns the instruction word to the IFU.
- Also sequences fence.i invalidation and flushes the array after a bus error.

---
 rtl/ysyx_23060236_icache_refill_if.sv | 26 ++
 rtl/ysyx_23060236_icache_refill.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060236_icache_refill.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_icache_refill_if.sv
// rtl/ysyx_23060236_icache_refill_if.sv - AXI4 read address/data channels used for instruction line refills
interface ysyx_23060236_icache_refill_if #(
  parameter int ADDR_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_23060236_icache_refill.sv
// rtl/ysyx_23060236_icache_refill.sv - IFU fetch lookup, AXI line refill, fence.i/error flush sequencing
// Optional hit/miss counters: YSYX_23060236_ICACHE_PERF_EN
module ysyx_23060236_icache_refill #(
  parameter int ADDR_W       = 32,
  parameter int CACHE_ADDR_W = 25,
  parameter int OFFSET_LEN   = 5,
  parameter int BEATS        = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_inst,
  output logic                    resp_err,
  input  logic                    fencei,
  output logic [CACHE_ADDR_W-1:0] icache_araddr,
  input  logic [31:0]             icache_rdata,
  input  logic                    icache_hit,
  output logic [CACHE_ADDR_W-1:0] icache_awaddr,
  output logic [31:0]             icache_wdata,
  output logic                    icache_wvalid,
  output logic                    icache_fencei,
`ifdef YSYX_23060236_ICACHE_PERF_EN
  output logic [31:0]             perf_hit_cnt,
  output logic [31:0]             perf_miss_cnt,
`endif
  ysyx_23060236_icache_refill_if.master axi
);
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_AR, S_R, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  beat_q;
  logic              fence_pend_q;
  logic              err_q;
  logic              err_flush_q;
  logic [31:0]       inst_q;
  logic              resp_err_q;

  logic [ADDR_W-1:0] line_base;
  logic              beat_bad;
  logic              burst_err;

  assign line_base = {addr_q[ADDR_W-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
  // A beat is bad on a non-OKAY response or when rlast disagrees with the beat count.
  assign beat_bad  = (axi.rresp != 2'b00) || (axi.rlast != (beat_q == CNT_W'(BEATS-1)));
  assign burst_err = err_q || beat_bad;

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    icache_fencei = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready     = !fence_pend_q;
        icache_fencei = fencei || fence_pend_q;
        if (req_valid && !fence_pend_q) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = icache_hit ? S_RESP : S_AR;
      S_AR:    if (axi.arready) state_nxt = S_R;
      S_R:     if (axi.rvalid && axi.rlast) state_nxt = burst_err ? S_RESP : S_CHECK;
      S_RESP: begin
        icache_fencei = err_flush_q;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      fence_pend_q <= 1'b0;
      err_q        <= 1'b0;
      err_flush_q  <= 1'b0;
      inst_q       <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_flush_q <= 1'b0;
      // Any flush pulse, including the error flush, also satisfies a pending fence.i.
      if (icache_fencei)  fence_pend_q <= 1'b0;
      else if (fencei)    fence_pend_q <= 1'b1;
      case (state)
        S_IDLE: if (req_valid && !fence_pend_q) addr_q <= req_addr;
        S_CHECK: if (icache_hit) begin
          inst_q     <= icache_rdata;
          resp_err_q <= 1'b0;
        end
        S_AR: if (axi.arready) begin
          beat_q <= '0;
          err_q  <= 1'b0;
        end
        S_R: if (axi.rvalid) begin
          beat_q <= beat_q + 1'b1;
          if (beat_bad) err_q <= 1'b1;
          if (axi.rlast && burst_err) begin
            inst_q      <= 32'h0;
            resp_err_q  <= 1'b1;
            err_flush_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid    = (state == S_RESP);
  assign resp_inst     = inst_q;
  assign resp_err      = resp_err_q;
  assign icache_araddr = addr_q[CACHE_ADDR_W-1:0];
  assign icache_awaddr = line_base[CACHE_ADDR_W-1:0] + CACHE_ADDR_W'({beat_q, 2'b00});
  assign icache_wdata  = axi.rdata;
  assign icache_wvalid = (state == S_R) && axi.rvalid;

  assign axi.arvalid = (state == S_AR);
  assign axi.araddr  = line_base;
  assign axi.arlen   = 8'(BEATS-1);
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.rready  = (state == S_R);

`ifdef YSYX_23060236_ICACHE_PERF_EN
  // Only the first lookup of a request is counted; the re-check after a refill is not.
  logic refilled_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refilled_q    <= 1'b0;
      perf_hit_cnt  <= 32'h0;
      perf_miss_cnt <= 32'h0;
    end else begin
      if (state == S_R && state_nxt == S_CHECK) refilled_q <= 1'b1;
      else if (state == S_IDLE)                 refilled_q <= 1'b0;
      if (state == S_CHECK && !refilled_q) begin
        if (icache_hit) begin
          if (perf_hit_cnt != 32'hFFFF_FFFF) perf_hit_cnt <= perf_hit_cnt + 32'h1;
        end else begin
          if (perf_miss_cnt != 32'hFFFF_FFFF) perf_miss_cnt <= perf_miss_cnt + 32'h1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_23060236_icache_refill.sv
// tb/tb_ysyx_23060236_icache_refill.sv - directed bench with array/bus models and per-cycle response scoreboard
`timescale 1ns/1ps
module tb_ysyx_23060236_icache_refill;
  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, fencei;
  logic [31:0] req_addr, resp_inst, icache_rdata, icache_wdata;
  logic [24:0] icache_araddr, icache_awaddr;
  logic        icache_hit, icache_wvalid, icache_fencei;
`ifdef YSYX_23060236_ICACHE_PERF_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  ysyx_23060236_icache_refill_if #(.ADDR_W(32)) axi ();

  ysyx_23060236_icache_refill dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .fencei(fencei),
    .icache_araddr(icache_araddr), .icache_rdata(icache_rdata), .icache_hit(icache_hit),
    .icache_awaddr(icache_awaddr), .icache_wdata(icache_wdata), .icache_wvalid(icache_wvalid),
    .icache_fencei(icache_fencei),
`ifdef YSYX_23060236_ICACHE_PERF_EN
    .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt),
`endif
    .axi(axi)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Backing memory: a known pattern for line 0xA000_0000, an address-derived word elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h5000000) return 32'h11 * (32'(a[4:2]) + 32'd1);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Direct-mapped array model: 32 lines, line becomes valid once its last word is written.
  logic [14:0] tag_m [32];
  logic [31:0] dat_m [256];
  logic [31:0] val_m;
  always @(posedge clock) begin
    if (!reset) val_m <= '0;
    else begin
      if (icache_fencei) val_m <= '0;
      if (icache_wvalid) begin
        dat_m[icache_awaddr[9:2]] <= icache_wdata;
        tag_m[icache_awaddr[9:5]] <= icache_awaddr[24:10];
        val_m[icache_awaddr[9:5]] <= (icache_awaddr[4:2] == 3'd7);
      end
    end
  end
  assign icache_hit   = val_m[icache_araddr[9:5]] && (tag_m[icache_araddr[9:5]] == icache_araddr[24:10]);
  assign icache_rdata = dat_m[icache_araddr[9:2]];

  logic [31:0] exp_base, exp_inst;
  logic        exp_err;
  int          drv_beat = 0;
  int          n_flush = 0, n_wr = 0;
  logic        flush_rr = 1'b1;

  // Scoreboard: every cycle, outputs against what the current fetch must produce.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (axi.arvalid) begin
          chk("araddr", axi.araddr, exp_base);
          chk("arlen", 32'(axi.arlen), 32'd7);
          chk("arsize", 32'(axi.arsize), 32'd2);
          chk("arburst", 32'(axi.arburst), 32'd1);
        end
        if (icache_wvalid) begin
          n_wr++;
          chk("wvalid_without_rvalid", 32'(axi.rvalid), 32'd1);
          chk("awaddr", 32'(icache_awaddr), 32'(exp_base[24:0] + 25'(4 * drv_beat)));
          chk("wdata", icache_wdata, mem_word(exp_base + 32'(4 * drv_beat)));
        end
        if (resp_valid) begin
          chk("resp_inst", resp_inst, exp_inst);
          chk("resp_err", 32'(resp_err), 32'(exp_err));
        end
        if (icache_fencei) begin
          n_flush++;
          flush_rr = req_ready;
          chk("flush_during_R", 32'(axi.rready), 32'd0);
        end
      end
    end
  end

  int          r_lat, r_ar, r_beats, r_resp_cyc;
  logic [31:0] last_inst, last_araddr;
  logic        last_err;

  task automatic fetch(input logic [31:0] a, input int ar_dly, input int gap, input int err_beat,
                       input int resp_dly, input int fence_beat, input int rst_beat, input bit fence_idle);
    int  acc_cyc, budget, ar_wait, rwait, beat, hold;
    bit  done, in_burst, start_burst;
    exp_base = {a[31:5], 5'b0};
    exp_err  = (err_beat >= 0);
    exp_inst = exp_err ? 32'h0 : mem_word(a);
    r_lat = -1; r_ar = 0; r_beats = 0; r_resp_cyc = 0;
    ar_wait = 0; rwait = 0; beat = 0; hold = 0; done = 0; in_burst = 0;
    @(negedge clock);
    req_addr  = a;
    req_valid = 1'b1;
    budget    = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    chk("req_accept_timeout", 32'(req_ready), 32'd1);
    fencei  = fence_idle;
    acc_cyc = cyc;
    budget  = 0;
    while (!done && budget < 300) begin
      @(negedge clock);
      budget++;
      req_valid   = 1'b0;
      fencei      = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rresp   = 2'b00;
      axi.arready = 1'b0;
      resp_ready  = 1'b0;
      start_burst = 1'b0;
      if (in_burst) begin
        if (rst_beat == beat) begin
          reset = 1'b0;
          #1;
          chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
          chk("rst_rready", 32'(axi.rready), 32'd0);
          chk("rst_resp_valid", 32'(resp_valid), 32'd0);
          @(negedge clock);
          reset = 1'b1;
          chk("rst_idle_ready", 32'(req_ready), 32'd1);
          done = 1'b1;
        end else if (rwait < gap) begin
          rwait++;
        end else begin
          drv_beat   = beat;
          axi.rvalid = 1'b1;
          axi.rdata  = mem_word(exp_base + 32'(4 * beat));
          axi.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          axi.rlast  = (beat == 7);
          if (beat == fence_beat) fencei = 1'b1;
          if (axi.rready) begin
            rwait = 0;
            r_beats++;
            beat++;
            if (beat == 8) in_burst = 1'b0;
          end
        end
      end
      if (axi.arvalid) begin
        last_araddr = axi.araddr;
        axi.arready = (ar_wait >= ar_dly);
        ar_wait++;
        if (axi.arready) begin
          r_ar++;
          start_burst = 1'b1;
          beat = 0;
        end
      end
      if (start_burst) in_burst = 1'b1;
      if (resp_valid) begin
        r_resp_cyc++;
        if (r_lat < 0) r_lat = cyc - acc_cyc;
        last_inst = resp_inst;
        last_err  = resp_err;
        if (hold >= resp_dly) begin
          resp_ready = 1'b1;
          done       = 1'b1;
        end else hold++;
      end
    end
    chk("fetch_timeout", 32'(done), 32'd1);
    @(negedge clock);
    resp_ready = 1'b0;
    fencei     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  int f0, w0;
  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0; fencei = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    exp_base = 32'h0; exp_inst = 32'h0; exp_err = 1'b0;
    idle(3);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_arvalid", 32'(axi.arvalid), 32'd0);
    chk("reset_rready", 32'(axi.rready), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_wvalid", 32'(icache_wvalid), 32'd0);
    chk("reset_fencei", 32'(icache_fencei), 32'd0);
`ifdef YSYX_23060236_ICACHE_PERF_EN
    chk("reset_perf_hit", perf_hit_cnt, 32'd0);
`endif
    reset = 1'b1;
    idle(2);

    // Cold miss
    w0 = n_wr;
    fetch(32'hA000_0004, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("cold_araddr", last_araddr, 32'hA000_0000);
    chk("cold_ar_count", 32'(r_ar), 32'd1);
    chk("cold_writes", 32'(n_wr - w0), 32'd8);
    chk("cold_inst", last_inst, 32'h0000_0022);
    chk("cold_err", 32'(last_err), 32'd0);

    // Hit after fill
    fetch(32'hA000_001C, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("hit_ar_count", 32'(r_ar), 32'd0);
    chk("hit_latency", 32'(r_lat), 32'd2);
    chk("hit_inst", last_inst, 32'h0000_0088);
`ifdef YSYX_23060236_ICACHE_PERF_EN
    chk("perf_hit", perf_hit_cnt, 32'd1);
    chk("perf_miss", perf_miss_cnt, 32'd1);
`endif

    // Backpressure on AR, R and response
    fetch(32'h8000_0048, 5, 2, -1, 4, -1, -1, 1'b0);
    chk("bp_ar_count", 32'(r_ar), 32'd1);
    chk("bp_beats", 32'(r_beats), 32'd8);
    chk("bp_resp_cycles", 32'(r_resp_cyc), 32'd5);
    chk("bp_inst", last_inst, 32'h0048_FFB7);

    // Bus error on beat 3
    f0 = n_flush;
    fetch(32'h8000_0080, 0, 0, 3, 0, -1, -1, 1'b0);
    idle(3);
    chk("err_beats", 32'(r_beats), 32'd8);
    chk("err_flushes", 32'(n_flush - f0), 32'd1);
    chk("err_inst", last_inst, 32'h0);
    chk("err_flag", 32'(last_err), 32'd1);
    fetch(32'h8000_0080, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("err_refetch_ar", 32'(r_ar), 32'd1);
    chk("err_refetch_inst", last_inst, 32'h0080_FF7F);

    // fence.i during refill is deferred to the first IDLE cycle
    f0 = n_flush;
    fetch(32'h8000_00C4, 0, 1, -1, 0, 2, -1, 1'b0);
    idle(3);
    chk("fence_mid_inst", last_inst, 32'h00C4_FF3B);
    chk("fence_mid_flushes", 32'(n_flush - f0), 32'd1);
    chk("fence_mid_req_ready", 32'(flush_rr), 32'd0);
    fetch(32'h8000_00C4, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("fence_refetch_ar", 32'(r_ar), 32'd1);

    // Error flush and pending fence.i merge into one pulse
    f0 = n_flush;
    fetch(32'h8000_0100, 0, 0, 5, 0, 1, -1, 1'b0);
    idle(4);
    chk("merge_flushes", 32'(n_flush - f0), 32'd1);
    chk("merge_err", 32'(last_err), 32'd1);

    // fence.i in IDLE alongside a request flushes before its lookup
    fetch(32'hA000_0010, 0, 0, -1, 0, -1, -1, 1'b0);
    fetch(32'hA000_0014, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("idle_fence_prehit_ar", 32'(r_ar), 32'd0);
    chk("idle_fence_prehit_inst", last_inst, 32'h0000_0066);
    f0 = n_flush;
    fetch(32'hA000_0018, 0, 0, -1, 0, -1, -1, 1'b1);
    chk("idle_fence_ar", 32'(r_ar), 32'd1);
    chk("idle_fence_flushes", 32'(n_flush - f0), 32'd1);
    chk("idle_fence_inst", last_inst, 32'h0000_0077);

    // Async reset during beat 4, then a fresh refill
    fetch(32'h8000_0140, 0, 0, -1, 0, -1, 4, 1'b0);
    chk("rst_beats_taken", 32'(r_beats), 32'd4);
    fetch(32'h8000_0140, 0, 0, -1, 0, -1, -1, 1'b0);
    chk("rst_refetch_ar", 32'(r_ar), 32'd1);
    chk("rst_refetch_inst", last_inst, 32'h0140_FEBF);

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
